memorybank_ch: RTL and testbench

- Cluster-head (CH) memory bank: a 32-entry × 16-bit register-file memory holding node-ID / cluster-head records for the routing/clustering engine.
- Synchronous single-port write; asynchronous (combinational) read addressed by the same index port.
- Sits beside the CH-selection controller, which writes node IDs and reads them back by slot index.

---
 rtl/memorybank_ch.sv | 83 ++++++++
 tb/tb_memorybank_ch.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memorybank_ch.sv
// ---------------------------------------------------------------------------
// memorybank_ch
//   Cluster-head memory bank. This is a register file that stores node-ID and
//   cluster-head records for the routing/clustering engine. It sits beside the
//   CH-selection controller, which writes node IDs and reads them back by slot
//   index.
//
//   Storage is flip-flop based, so no SRAM macro is inferred.
//     - Write: synchronous, single port, on the rising clk edge.
//     - Read:  asynchronous (combinational), using the same index port as the
//              write.
//
// Parameters
//   WORD_WIDTH  data word width in bits                  (default 16)
//   MEM_DEPTH   number of entries                        (default 32)
//   ADDR_WIDTH  index width, 2**ADDR_WIDTH >= MEM_DEPTH  (default 5)
//
// Ports
//   clk       in   1           system clock; state updates on the rising edge
//   nrst      in   1           asynchronous active-low reset; clears every entry
//   wr_en     in   1           write enable, sampled on the rising clk edge
//   index     in   ADDR_WIDTH  entry address for both write and read
//   data_in   in   WORD_WIDTH  write data
//   data_out  out  WORD_WIDTH  contents of entry[index]; reads 0 when index is
//                              out of range
//
// Build option
//   MEMBANK_CH_WRBYPASS_EN
//     When this macro is defined, data_in is driven straight onto data_out
//     whenever wr_en=1 and nrst=1. The write data is then visible in the same
//     cycle as the write. When it is undefined, data_out reflects the stored
//     contents only.
// ---------------------------------------------------------------------------
module memorybank_ch #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned MEM_DEPTH  = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] index,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] data_out
);

    logic [WORD_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  in_range;
    logic [WORD_WIDTH-1:0] stored_word;

    // Only indices below MEM_DEPTH are backed by storage. With the default
    // parameters every index is valid, so this is constant true.
    assign in_range = (32'(index) < MEM_DEPTH);

    // Reset clears every entry and takes priority over a concurrent write.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && in_range) begin
            mem[index] <= data_in;
        end
    end

    always_comb begin
        stored_word = '0;
        if (in_range) begin
            stored_word = mem[index];
        end
    end

    always_comb begin
        data_out = stored_word;
`ifdef MEMBANK_CH_WRBYPASS_EN
        // Write-through: show the incoming word before the edge that stores it.
        if (wr_en && nrst) begin
            data_out = data_in;
        end
`endif
    end

endmodule

// File: tb/tb_memorybank_ch.sv
// ---------------------------------------------------------------------------
// tb_memorybank_ch
//   Self-checking bench for memorybank_ch. It keeps a reference memory that is
//   updated from the write rules. Expected read values come from that memory,
//   or from data_in while a write is in flight when MEMBANK_CH_WRBYPASS_EN is
//   defined.
// ---------------------------------------------------------------------------
module tb_memorybank_ch;

    localparam int unsigned WW = 16;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW = 5;

    logic          clk;
    logic          nrst;
    logic          wr_en;
    logic [AW-1:0] index;
    logic [WW-1:0] data_in;
    logic [WW-1:0] data_out;

    logic [WW-1:0] model [DEPTH];
    logic [WW-1:0] exp_v;
    int total;
    int bad;

    memorybank_ch #(
        .WORD_WIDTH(WW),
        .MEM_DEPTH (DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .wr_en   (wr_en),
        .index   (index),
        .data_in (data_in),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Expected read for the current inputs.
    function automatic logic [WW-1:0] expect_read(input logic [AW-1:0] idx,
                                                  input logic we,
                                                  input logic rn,
                                                  input logic [WW-1:0] din);
`ifdef MEMBANK_CH_WRBYPASS_EN
        if (we && rn) return din;
`endif
        if (!rn) return '0;
        return model[idx];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    endfunction

    // One-edge write. Inputs change on the falling edge; the model is updated
    // together with the rising edge.
    task automatic write_word(input logic [AW-1:0] idx, input logic [WW-1:0] d);
        @(negedge clk);
        index = idx;
        data_in = d;
        wr_en = 1'b1;
        @(posedge clk);
        model[idx] = d;
        #1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        wr_en = 1'b0;
        data_in = '0;
        index = '0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < int'(DEPTH); i++) begin
            index = AW'(i);
            #1;
            total++;
            if (data_out !== '0) begin
                bad++;
                $display("FAIL reset_sweep idx=%0d got=%h want=0000", i, data_out);
            end
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_basic();
        write_word(5'd0, 16'd87);
        index = 5'd0;
        #1;
        total++;
        if (data_out !== 16'd87) begin
            bad++;
            $display("FAIL basic_rd idx=0 got=%0d want=87", data_out);
        end
    endtask

    task automatic test_second_entry();
        write_word(5'd2, 16'd15);
        index = 5'd0;
        #1;
        total++;
        if (data_out !== 16'd87) begin
            bad++;
            $display("FAIL second_rd0 got=%0d want=87", data_out);
        end
        index = 5'd2;
        #1;
        total++;
        if (data_out !== 16'd15) begin
            bad++;
            $display("FAIL second_rd2 got=%0d want=15", data_out);
        end
    endtask

    task automatic test_hold_no_write();
        @(negedge clk);
        index = 5'd4;
        data_in = 16'd23;
        wr_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (data_out !== 16'd0) begin
                bad++;
                $display("FAIL hold_idle cyc=%0d got=%0d want=0", c, data_out);
            end
        end
        write_word(5'd4, 16'd23);
        #1;
        total++;
        if (data_out !== 16'd23) begin
            bad++;
            $display("FAIL hold_pulse got=%0d want=23", data_out);
        end
        index = 5'd2;
        #1;
        total++;
        if (data_out !== 16'd15) begin
            bad++;
            $display("FAIL hold_reread2 got=%0d want=15", data_out);
        end
    endtask

    task automatic test_boundary();
        write_word(5'd31, 16'hFFFF);
        write_word(5'd0, 16'hA5A5);
        write_word(5'd0, 16'h0001);
        index = 5'd31;
        #1;
        total++;
        if (data_out !== 16'hFFFF) begin
            bad++;
            $display("FAIL bound_31 got=%h want=ffff", data_out);
        end
        index = 5'd0;
        #1;
        total++;
        if (data_out !== 16'h0001) begin
            bad++;
            $display("FAIL bound_ovr0 got=%h want=0001", data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [WW-1:0] vals [4];
        vals[0] = 16'h1111;
        vals[1] = 16'h2222;
        vals[2] = 16'h3333;
        vals[3] = 16'h4444;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wr_en = 1'b1;
            index = AW'(5 + k);
            data_in = vals[k];
            @(posedge clk);
            model[5 + k] = vals[k];
        end
        @(negedge clk);
        wr_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            index = AW'(5 + k);
            #1;
            total++;
            if (data_out !== vals[k]) begin
                bad++;
                $display("FAIL b2b idx=%0d got=%h want=%h", 5 + k, data_out, vals[k]);
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        index = 5'd3;
        data_in = 16'h1234;
        wr_en = 1'b1;
        #1;
        exp_v = expect_read(5'd3, 1'b1, 1'b1, 16'h1234);
        total++;
        if (data_out !== exp_v) begin
            bad++;
            $display("FAIL bypass_pre got=%h want=%h", data_out, exp_v);
        end
        @(posedge clk);
        model[3] = 16'h1234;
        #1;
        total++;
        if (data_out !== 16'h1234) begin
            bad++;
            $display("FAIL bypass_post got=%h want=1234", data_out);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        index = 5'd31;
        #2;
        nrst = 1'b0;
        model_clear();
        #1;
        total++;
        if (data_out !== '0) begin
            bad++;
            $display("FAIL async_clr got=%h want=0000", data_out);
        end
        // Reset must beat a write on an edge seen while nrst is low.
        wr_en = 1'b1;
        data_in = 16'hBEEF;
        index = 5'd9;
        @(posedge clk);
        #1;
        total++;
        if (data_out !== expect_read(5'd9, 1'b1, 1'b0, 16'hBEEF)) begin
            bad++;
            $display("FAIL rst_prio got=%h want=0000", data_out);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        model[9] = 16'hBEEF;
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        total++;
        if (data_out !== 16'hBEEF) begin
            bad++;
            $display("FAIL rst_first_wr got=%h want=beef", data_out);
        end
        index = 5'd0;
        #1;
        total++;
        if (data_out !== 16'h0000) begin
            bad++;
            $display("FAIL rst_cleared0 got=%h want=0000", data_out);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            wr_en = 1'($urandom_range(0, 1));
            index = AW'($urandom_range(0, DEPTH - 1));
            data_in = WW'($urandom);
            #1;
            exp_v = expect_read(index, wr_en, 1'b1, data_in);
            total++;
            if (data_out !== exp_v) begin
                bad++;
                $display("FAIL rnd_pre n=%0d idx=%0d got=%h want=%h", n, index, data_out, exp_v);
            end
            // Changes between edges must not affect storage.
            if (!wr_en) begin
                index = AW'($urandom_range(0, DEPTH - 1));
                #1;
                total++;
                if (data_out !== model[index]) begin
                    bad++;
                    $display("FAIL rnd_follow n=%0d idx=%0d got=%h want=%h", n, index, data_out, model[index]);
                end
            end
            @(posedge clk);
            if (wr_en) model[index] = data_in;
            #1;
            exp_v = expect_read(index, wr_en, 1'b1, data_in);
            total++;
            if (data_out !== exp_v) begin
                bad++;
                $display("FAIL rnd_post n=%0d idx=%0d got=%h want=%h", n, index, data_out, exp_v);
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            index = AW'(i);
            #1;
            total++;
            if (data_out !== model[i]) begin
                bad++;
                $display("FAIL rnd_sweep idx=%0d got=%h want=%h", i, data_out, model[i]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_second_entry();
        test_hold_no_write();
        test_boundary();
        test_back_to_back();
        test_bypass();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
